// File: rtl/hwpf_nl_deg_pkg.sv
// Shared types for the next-N-line prefetcher: CPU/arbiter request layouts,
// history entry, generator states and the same-page helper.
package hwpf_nl_deg_pkg;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned RD_W   = 5;

  localparam logic [3:0] HPDCACHE_REQ_CMD_PREFETCH = 4'h8;

  typedef logic [ADDR_W-1:0] hwpf_line_t;

  typedef struct packed {
    logic              valid;
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] io_base_addr;
  } req_cpu_dcache_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic [3:0]        op;
    logic [7:0]        be;
    logic [2:0]        size;
    logic [2:0]        sid;
    logic [5:0]        tid;
    logic              need_rsp;
    logic              uncacheable;
  } hpdcache_req_t;

  typedef struct packed {
    logic       valid;
    hwpf_line_t line;
  } hist_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } hwpf_gen_state_e;

  // lines_log2 = log2(lines per page)
  function automatic logic same_page(hwpf_line_t a, hwpf_line_t b, int unsigned lines_log2);
    return (a >> lines_log2) == (b >> lines_log2);
  endfunction

endpackage

// File: rtl/hwpf_nl_fifo.sv
// Parametrised FIFO used as the prefetch issue queue; push is refused when the
// registered count is full, even if a pop happens in the same cycle.
module hwpf_nl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hwpf_nl_deg.sv
// Next-N-line data prefetcher: trains on CPU requests via an LRU line history and
// issues up to DEGREE same-page lines ahead. Option: HWPF_NL_DEG_BYPASS_EN.
module hwpf_nl_deg
  import hwpf_nl_deg_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = 64,
  parameter int unsigned HIST_DEPTH  = 8,
  parameter int unsigned DEGREE      = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PAGE_BYTES  = 4096
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            lock_i,
  input  req_cpu_dcache_t cpu_req_i,
  output logic            arbiter_req_valid_o,
  input  logic            arbiter_req_ready_i,
  output hpdcache_req_t   arbiter_req_o
);

  localparam int unsigned LB_W  = $clog2(LINE_BYTES);
  localparam int unsigned PG_W  = $clog2(PAGE_BYTES) - LB_W;
  localparam int unsigned IDX_W = $clog2(HIST_DEPTH);
  localparam int unsigned K_W   = 4;
  localparam logic [IDX_W-1:0] LRU_IDX = IDX_W'(HIST_DEPTH - 1);

  hist_entry_t     hist_q [HIST_DEPTH];
  hist_entry_t     hist_d [HIST_DEPTH];
  hwpf_gen_state_e state_q, state_d;
  hwpf_line_t      base_q, base_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            req_valid_q, req_valid_d;
  hwpf_line_t      req_line_q, req_line_d;
  logic            last_valid_q, last_valid_d;
  logic [RD_W-1:0] last_rd_q, last_rd_d;
  hwpf_line_t      last_line_q, last_line_d;

  hwpf_line_t      cpu_line, cand, head_line, out_line;
  logic            new_req, lookup_act, look_hit, cand_hit;
  logic [IDX_W-1:0] look_idx, wr_idx;
  logic            wr_en;
  hwpf_line_t      wr_line;
  logic            gen_act, cand_in_page, gen_push, gen_adv;
  logic            q_push, q_pop, q_full, q_empty, out_have;

  assign cpu_line = hwpf_line_t'(cpu_req_i.io_base_addr >> LB_W);
  assign new_req  = cpu_req_i.valid &
                    (~last_valid_q | (cpu_req_i.rd != last_rd_q) | (cpu_line != last_line_q));
  assign cand     = base_q + hwpf_line_t'(k_q);

  always_comb begin
    look_hit = 1'b0;
    look_idx = LRU_IDX;
    cand_hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (hist_q[i].valid && hist_q[i].line == req_line_q) begin
        look_hit = 1'b1;
        look_idx = IDX_W'(i);
      end
      if (hist_q[i].valid && hist_q[i].line == cand) cand_hit = 1'b1;
    end
  end

  // The lookup stage owns the single history write port; the generator waits.
  assign lookup_act   = req_valid_q & ~lock_i;
  assign gen_act      = (state_q == GEN) & ~lock_i & ~lookup_act;
  assign cand_in_page = same_page(cand, base_q, PG_W);
  assign gen_push     = gen_act & cand_in_page & ~cand_hit & ~q_full;
  assign gen_adv      = gen_act & cand_in_page & (cand_hit | ~q_full);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    if (lookup_act && look_hit) begin
      state_d = GEN;
      k_d     = K_W'(1);
      base_d  = req_line_q;
    end else if (gen_act) begin
      if (!cand_in_page) begin
        state_d = IDLE;
      end else if (gen_adv) begin
        if (k_q == K_W'(DEGREE)) state_d = IDLE;
        else                     k_d     = k_q + K_W'(1);
      end
    end
  end

  // Writing a line to MRU shifts entries [0, wr_idx-1] down by one; a miss drops the LRU.
  always_comb begin
    wr_en   = 1'b0;
    wr_line = req_line_q;
    wr_idx  = LRU_IDX;
    if (lookup_act) begin
      wr_en  = 1'b1;
      wr_idx = look_hit ? look_idx : LRU_IDX;
    end else if (gen_push) begin
      wr_en   = 1'b1;
      wr_line = cand;
    end
    for (int i = 0; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i];
    if (wr_en) begin
      hist_d[0] = '{valid: 1'b1, line: wr_line};
      for (int i = 1; i < HIST_DEPTH; i++) begin
        if (IDX_W'(i) <= wr_idx) hist_d[i] = hist_q[i-1];
      end
    end
  end

  always_comb begin
    req_valid_d  = req_valid_q;
    req_line_d   = req_line_q;
    last_valid_d = last_valid_q;
    last_rd_d    = last_rd_q;
    last_line_d  = last_line_q;
    if (!lock_i) begin
      req_valid_d = new_req;
      if (new_req) begin
        req_line_d   = cpu_line;
        last_valid_d = 1'b1;
        last_rd_d    = cpu_req_i.rd;
        last_line_d  = cpu_line;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || flush_i) begin
      if (!rst_ni || flush_i) begin
        for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        state_q      <= IDLE;
        base_q       <= '0;
        k_q          <= '0;
        req_valid_q  <= 1'b0;
        req_line_q   <= '0;
        last_valid_q <= 1'b0;
        last_rd_q    <= '0;
        last_line_q  <= '0;
      end
    end else begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= hist_d[i];
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      req_valid_q  <= req_valid_d;
      req_line_q   <= req_line_d;
      last_valid_q <= last_valid_d;
      last_rd_q    <= last_rd_d;
      last_line_q  <= last_line_d;
    end
  end

`ifdef HWPF_NL_DEG_BYPASS_EN
  logic bypass;
  assign bypass              = gen_push & q_empty;
  assign out_have            = ~q_empty | bypass;
  assign out_line            = q_empty ? cand : head_line;
  assign arbiter_req_valid_o = ~lock_i & out_have;
  assign q_push              = gen_push & ~(bypass & arbiter_req_ready_i);
  assign q_pop               = ~lock_i & ~q_empty & arbiter_req_ready_i;
`else
  assign out_have            = ~q_empty;
  assign out_line            = head_line;
  assign arbiter_req_valid_o = ~lock_i & ~q_empty;
  assign q_push              = gen_push;
  assign q_pop               = arbiter_req_valid_o & arbiter_req_ready_i;
`endif

  always_comb begin
    arbiter_req_o = '0;
    if (out_have) begin
      arbiter_req_o.addr = out_line << LB_W;
      arbiter_req_o.op   = HPDCACHE_REQ_CMD_PREFETCH;
    end
  end

  hwpf_nl_fifo #(
    .WIDTH ($bits(hwpf_line_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_issue_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (q_push),
    .data_i  (cand),
    .pop_i   (q_pop),
    .data_o  (head_line),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_hwpf_nl_deg.sv
// Self-checking bench for hwpf_nl_deg: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_hwpf_nl_deg;
  import hwpf_nl_deg_pkg::*;

  localparam int LINE_BYTES = 64;
  localparam int PAGE_BYTES = 4096;
  localparam int HD         = 8;
  localparam int DEG        = 2;
  localparam int QD         = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            lock = 1'b0;
  logic            ready = 1'b1;
  req_cpu_dcache_t cpu_req = '0;
  logic            valid, valid8;
  hpdcache_req_t   req, req8;

  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] issued[$];
  logic [63:0] issued8[$];

  always #5 clk = ~clk;

  hwpf_nl_deg #(.LINE_BYTES(LINE_BYTES), .HIST_DEPTH(HD), .DEGREE(DEG),
                .QUEUE_DEPTH(QD), .PAGE_BYTES(PAGE_BYTES)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .cpu_req_i(cpu_req), .arbiter_req_valid_o(valid),
    .arbiter_req_ready_i(ready), .arbiter_req_o(req));

  hwpf_nl_deg #(.LINE_BYTES(LINE_BYTES), .HIST_DEPTH(HD), .DEGREE(8),
                .QUEUE_DEPTH(QD), .PAGE_BYTES(PAGE_BYTES)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .cpu_req_i(cpu_req), .arbiter_req_valid_o(valid8),
    .arbiter_req_ready_i(ready), .arbiter_req_o(req8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: history as an MRU-first queue, issue queue as a plain queue.
  hwpf_line_t m_hist[$];
  hwpf_line_t m_fifo[$];
  bit         m_gen, m_req_v, m_last_v;
  hwpf_line_t m_base, m_req_line, m_last_line;
  int         m_k, m_last_rd;

  function automatic void m_reset();
    m_hist.delete(); m_fifo.delete();
    m_gen = 0; m_req_v = 0; m_last_v = 0;
    m_base = '0; m_req_line = '0; m_last_line = '0; m_k = 0; m_last_rd = 0;
  endfunction

  function automatic int m_find(hwpf_line_t l);
    foreach (m_hist[i]) if (m_hist[i] == l) return i;
    return -1;
  endfunction

  function automatic void m_touch(hwpf_line_t l);
    int idx = m_find(l);
    if (idx >= 0) m_hist.delete(idx);
    m_hist.push_front(l);
    if (m_hist.size() > HD) void'(m_hist.pop_back());
  endfunction

  function automatic void m_eval(output bit act, output bit same, output bit inh,
                                 output bit push, output hwpf_line_t c);
    act  = m_gen && !lock && !m_req_v;
    c    = m_base + hwpf_line_t'(m_k);
    same = (64'(c) * LINE_BYTES / PAGE_BYTES) == (64'(m_base) * LINE_BYTES / PAGE_BYTES);
    inh  = m_find(c) >= 0;
    push = act && same && !inh && m_fifo.size() < QD;
  endfunction

  function automatic void m_outputs(output bit v, output hwpf_line_t ln);
    bit act, same, inh, p;
    hwpf_line_t c;
    m_eval(act, same, inh, p, c);
    v  = !lock && m_fifo.size() > 0;
    ln = '0;
    if (m_fifo.size() > 0) ln = m_fifo[0];
`ifdef HWPF_NL_DEG_BYPASS_EN
    if (m_fifo.size() == 0 && p) begin v = 1; ln = c; end
`endif
  endfunction

  function automatic void m_step();
    bit act, same, inh, p, v, byp, hit, newr;
    hwpf_line_t c, ln, cl;
    m_eval(act, same, inh, p, c);
    m_outputs(v, ln);
    byp = 0;
`ifdef HWPF_NL_DEG_BYPASS_EN
    byp = p && m_fifo.size() == 0 && ready;
`endif
    if (v && ready && !byp) void'(m_fifo.pop_front());
    if (p && !byp) m_fifo.push_back(c);
    if (act) begin
      if (!same) m_gen = 0;
      else if (inh || p) begin
        if (p) m_touch(c);
        if (m_k == DEG) m_gen = 0;
        else m_k++;
      end
    end
    if (m_req_v) begin
      hit = m_find(m_req_line) >= 0;
      m_touch(m_req_line);
      if (hit) begin m_gen = 1; m_base = m_req_line; m_k = 1; end
    end
    cl   = cpu_req.io_base_addr / LINE_BYTES;
    newr = cpu_req.valid && (!m_last_v || int'(cpu_req.rd) != m_last_rd || cl != m_last_line);
    m_req_v = newr;
    if (newr) begin
      m_req_line = cl; m_last_v = 1; m_last_rd = int'(cpu_req.rd); m_last_line = cl;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) m_reset();
    else if (!lock) m_step();
  end

  always @(negedge clk) begin
    bit ev;
    hwpf_line_t eln;
    if (rst_n) begin
      m_outputs(ev, eln);
      chk("model_valid", valid, ev);
      if (ev) begin
        chk("model_addr", req.addr, 64'(eln * LINE_BYTES));
        chk("model_op", req.op, HPDCACHE_REQ_CMD_PREFETCH);
      end
      if (valid && ready) issued.push_back(64'(req.addr));
      if (valid8 && ready) issued8.push_back(64'(req8.addr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] addr, input int rd);
    cpu_req.valid = 1'b1;
    cpu_req.rd = RD_W'(rd);
    cpu_req.io_base_addr = ADDR_W'(addr);
    tick();
    cpu_req.valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  function automatic logic [63:0] at(input bit which8, input int i);
    if (!which8 && i < issued.size()) return issued[i];
    if (which8 && i < issued8.size()) return issued8[i];
    return '1;
  endfunction

  initial begin
    hpdcache_req_t r;
    m_reset();
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_req_zero", 64'(|req), 0);
    @(negedge clk); rst_n = 1'b1;
    tick(2);

    // next two lines, with N+3 latency
    issued.delete();
    send(64'h1000, 1);
    send(64'h1000, 2);
    tick(); chk("lat_n2_valid", valid, 0);
    tick(); chk("lat_n3_valid", valid, 1);
    chk("lat_n3_addr", req.addr, 64'h1040);
    r = req; r.addr = '0; r.op = '0;
    chk("req_other_fields", 64'(|r), 0);
    tick(8);
    chk("t1_count", issued.size(), 2);
    chk("t1_first", at(0, 0), 64'h1040);
    chk("t1_second", at(0, 1), 64'h1080);

    // page boundary
    issued.delete();
    send(64'h1F80, 1); send(64'h1F80, 2);
    tick(10);
    chk("page_count", issued.size(), 1);
    chk("page_addr", at(0, 0), 64'h1FC0);

    // prefetched lines already in history
    issued.delete();
    send(64'h1000, 1); send(64'h1000, 2);
    tick(10);
    chk("hist_skip_count", issued.size(), 0);

    // queue full stall on the degree-8 instance
    ready = 1'b0; do_flush();
    issued8.delete();
    send(64'h4000, 1); send(64'h4000, 2);
    tick(12);
    chk("stall_valid", valid8, 1);
    chk("stall_head", req8.addr, 64'h4040);
    ready = 1'b1;
    tick(20);
    chk("stall_count", issued8.size(), 8);
    for (int i = 0; i < 8; i++) chk("stall_order", at(1, i), 64'h4040 + 64'(i) * 64);

    // lock holds the queue, flush empties it
    ready = 1'b0; do_flush();
    issued.delete();
    send(64'h8000, 1); send(64'h8000, 2);
    tick(6);
    chk("lock_pre_valid", valid, 1);
    lock = 1'b1; ready = 1'b1;
    tick(3);
    chk("lock_valid", valid, 0);
    chk("lock_no_pop", issued.size(), 0);
    lock = 1'b0;
    tick(4);
    chk("unlock_count", issued.size(), 2);
    chk("unlock_first", at(0, 0), 64'h8040);
    chk("unlock_second", at(0, 1), 64'h8080);
    ready = 1'b0;
    send(64'h9000, 1); send(64'h9000, 2);
    tick(6);
    chk("flush_pre_valid", valid, 1);
    do_flush();
    chk("flush_valid", valid, 0);
    tick(4);
    chk("flush_stays_empty", valid, 0);

    // async reset during generation
    send(64'h1000, 1); send(64'h1000, 2);
    tick(2);
    chk("rst_pre_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_valid", valid, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ready = 1'b1;
    tick(2);
    issued.delete();
    send(64'h1000, 1);
    tick(8);
    chk("rst_hist_cleared", issued.size(), 0);

    // randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      cpu_req.valid = ($urandom_range(0, 9) < 4);
      cpu_req.rd = RD_W'($urandom_range(0, 3));
      cpu_req.io_base_addr = ADDR_W'(64'(32'h3F8 + $urandom_range(0, 15)) * LINE_BYTES
                                     + 64'($urandom_range(0, 63)));
      ready = ($urandom_range(0, 9) < 7);
      lock  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end
    cpu_req.valid = 1'b0; lock = 1'b0; flush = 1'b0; ready = 1'b1;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hwpf_nl_deg.md
# hwpf_nl_deg

Parametrised next-N-line prefetcher for the Sargantana data cache. It trains on CPU load/store requests using a small recent-line history. Once a line has been seen twice, it emits up to DEGREE sequential prefetch requests, buffered through an issue queue, into the HPDcache request arbiter. It is the successor of the single-line next-line prefetcher and adds configurable degree, history depth, queue depth and page-boundary filtering.

## Interface
Parameters:
- LINE_BYTES, 64, cache line size in bytes; power of two.
- HIST_DEPTH, 8, history entries (recent lines); ≥2.
- DEGREE, 2, lines ahead generated per trigger; 1..8.
- QUEUE_DEPTH, 4, issue-queue entries; power of two, ≥2.
- PAGE_BYTES, 4096, prefetch candidates never cross this boundary.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous clear of history, generator and queue.
- lock_i  in  1  freezes training, generation and issue.
- cpu_req_i  in  req_cpu_dcache_t  CPU request to the dcache (valid, rd, io_base_addr used).
- arbiter_req_valid_o  out  1  prefetch request valid.
- arbiter_req_ready_i  in  1  arbiter accepts the request.
- arbiter_req_o  out  hpdcache_req_t  prefetch request.

## Operation
- New request: cpu_req_i.valid=1 and {rd, line} ≠ last captured {rd, line}. line = io_base_addr >> log2(LINE_BYTES). A new request is captured into req_q.
- Lookup stage (req_q valid):
  - History miss: insert the line at MRU. The LRU entry drops. No trigger.
  - History hit: promote the line to MRU. Trigger the generator with base = line; this overrides any generation in progress.
- Generator FSM:
  - IDLE: on trigger, go to GEN with k=1.
  - GEN: evaluate candidate base+k, one per cycle.
    - If the candidate is in a different PAGE_BYTES page from base: go to IDLE.
    - If the candidate is in history: skip it, k++.
    - Otherwise, if the queue is not full: push the candidate, insert it at MRU, k++.
    - If the queue is full: hold k.
    - After k=DEGREE is handled: go to IDLE.
- A lookup-stage history write takes priority over a generator write. The generator stalls that cycle, so there is one history write per cycle.
- Issue queue: FIFO. arbiter_req_valid_o = ~lock_i & ~empty; the head drives arbiter_req_o. Pop on valid & ready.
  - Push is allowed only when the registered count < QUEUE_DEPTH; a same-cycle pop does not free a slot.
  - Push and pop in the same cycle at non-full leaves the count unchanged.
- arbiter_req_o fields:
  - addr = line << log2(LINE_BYTES).
  - op = HPDCACHE_REQ_CMD_PREFETCH.
  - need_rsp=0, uncacheable=0, sid=0, tid=0.
  - All other fields 0.
- Line arithmetic wraps modulo the line-address width. The page check catches wrap in practice.
- lock_i=1: no capture, no lookup, generator holds state and k, valid_o=0. Queue and history contents are retained.
- flush_i=1: next cycle, history valids=0, queue empty, FSM=IDLE, req_q invalid, last {rd, line} cleared. Flush has priority over every same-cycle event, including lock_i.

## Timing
- Reset values: arbiter_req_valid_o=0, arbiter_req_o all zero, FSM=IDLE, history and queue empty, req_q invalid.
- The cycle numbers below are counted with no lock and no full queue.
- CPU request at cycle N: lookup at N+1; on a hit, the FSM is in GEN at N+2. The first candidate is pushed at the end of N+2, and arbiter_req_valid_o=1 at N+3.
- DEGREE unskipped candidates are pushed at N+2..N+1+DEGREE.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-generation or mid-handshake: all state returns to reset values immediately, and a pending request is dropped.

## Configuration
- HWPF_NL_DEG_BYPASS_EN defined:
  - When the queue is empty, lock_i=0 and the generator pushes, the candidate is presented on arbiter_req_o in the same cycle.
  - If ready=1, it is consumed and not enqueued; otherwise it is enqueued as normal.
  - Latency becomes N+2.
- Undefined: the output is driven only from the queue head, with N+3 latency.

## Structure
- Package hwpf_nl_deg_pkg:
  - hwpf_line_t.
  - hist_entry_t {valid, line}.
  - hwpf_gen_state_e {IDLE, GEN}.
  - Helper function for same-page compare.
- Sub-module hwpf_nl_fifo: parametrised width/depth FIFO with push, pop, full, empty, flush. It is instantiated once for the issue queue.

## Test plan
- Addr 0x1000 twice (rd 1 then rd 2), DEGREE=2 → arbiter requests 0x1040 then 0x1080; first valid at the 3rd cycle after the second request.
- Addr 0x1F80 twice, DEGREE=2, PAGE_BYTES=4096 → only 0x1FC0 is issued; 0x2000 is suppressed and the FSM returns to IDLE.
- Repeat the 0x1000 pair after the previous prefetches → 0x1040/0x1080 are history hits, so no new requests are issued.
- arbiter_req_ready_i=0, QUEUE_DEPTH=4, DEGREE=8 on 0x4000 → exactly 4 requests queued and the generator stalls. Raise ready → the remaining 4 are issued in order, 0x4040..0x4200.
- lock_i=1 during a pending queue of 2 → valid_o=0, no pops. Release → the same 2 addresses are issued. flush_i then empties everything and valid_o=0 on the next cycle.
- rst_ni low during GEN with 1 queued request → valid_o=0 immediately. After release, a single 0x1000 access produces no prefetch (history cleared).
